fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 2: instruction buffer entries and maximum combined in-flight plus buffered fetches; legal range 2..8.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: fetch address after reset.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  fetch request; memory accepts every request in the cycle it is asserted.
REQ-006 imem_addr  output  32  word-aligned fetch address, valid while imem_req=1.
REQ-007 imem_rvalid  input  1  response strobe; responses return in request order, latency >=1 cycle.
REQ-008 imem_rdata  input  32  instruction word, valid with imem_rvalid.
REQ-009 instr_valid  output  1  instr/instr_pc hold a buffered instruction.
REQ-010 instr  output  32  instruction word to decode (op=instr[27:26], funct=instr[25:20], rd=instr[15:12]).
REQ-011 instr_pc  output  32  address of instr.
REQ-012 instr_ready  input  1  decode consumes instr this cycle when instr_valid=1.
REQ-013 redirect  input  1  taken branch or PC write from execute (pcs gated by condition).
REQ-014 redirect_pc  input  32  new fetch address, valid with redirect; bits [1:0] ignored, treated as 0.

Function
REQ-015 Counters: cnt = buffered entries, outst = requests issued without response yet, disc = in-flight responses to drop.
REQ-016 imem_req = !redirect && (cnt + outst - disc < DEPTH); imem_addr = fetch_pc; fetch_pc += 4 per request (wraps at 2^32).
REQ-017 A response arriving with disc=0 is written to the buffer tail with tag resp_pc; resp_pc += 4; outst decrements.
REQ-018 A response arriving with disc>0 is dropped; disc and outst both decrement.
REQ-019 Buffer never overflows: REQ-016 guarantees a free entry for every accepted response.
REQ-020 Handshake: instr_valid=1 and instr_ready=1 pops head; instr/instr_pc change only on pop, push to empty buffer, or flush; instr=0 and instr_pc=0 when empty.
REQ-021 Simultaneous push and pop with cnt=DEPTH-1 or cnt=DEPTH: both occur, cnt adjusts by net 0.
REQ-022 Redirect: a same-cycle pop completes first; then buffer flushes (cnt=0); fetch_pc and resp_pc load redirect_pc; disc = outst after same-cycle response handling; any same-cycle response is dropped.
REQ-023 Redirect suppresses imem_req that cycle; first fetch of redirect_pc is requested the next cycle.
REQ-024 Back-to-back redirects: last one wins; disc accumulates correctly per REQ-022.
REQ-025 Throughput: with 1-cycle memory, no redirects, and instr_ready=1, one instruction per cycle after startup.

Reset
REQ-026 On reset=1: fetch_pc=resp_pc=RESET_PC; cnt=outst=disc=0; imem_req=0; instr_valid=0; instr=0; instr_pc=0.
REQ-027 Reset asserted mid-operation discards all buffered and in-flight fetches; responses arriving during reset are ignored; the memory is reset in the same cycle.
REQ-028 First request (imem_addr=RESET_PC) is issued in the first cycle after reset deasserts.

Configuration
REQ-029 Macro FETCH_BYPASS_EN defined: when the buffer is empty, disc=0, no redirect and imem_rvalid=1, imem_rdata and resp_pc drive instr/instr_pc combinationally with instr_valid=1; if instr_ready=1 the entry is not buffered.
REQ-030 FETCH_BYPASS_EN undefined: every response is buffered first; instr_valid rises the cycle after imem_rvalid at the earliest.

Structure
REQ-031 Package fetch_pkg holds WORD_W=32, PC_STEP=4, the default RESET_PC, and typedef fetch_entry_t {pc[31:0], instr[31:0]}.
REQ-032 Sub-module fetch_fifo (DEPTH entries of fetch_entry_t, push/pop/flush, count output) holds the buffer; counters and PC logic stay in fetch_unit.

Verification
REQ-033 Reset release, 1-cycle memory, instr_ready=1 -> imem_addr 0,4,8,...; instr_pc 0,4,8 on consecutive cycles from cycle 2 (cycle 1 with FETCH_BYPASS_EN).
REQ-034 instr_ready=0 for 10 cycles, DEPTH=2 -> imem_req drops after 2 requests; cnt=2; no response lost; instr_pc=0 held.
REQ-035 3-cycle memory latency, redirect to 32'h100 with outst=2 -> both stale responses dropped; next instr_pc=32'h100, then 32'h104.
REQ-036 Redirect in the same cycle as imem_rvalid and a pop -> popped instruction counted consumed; response dropped; buffer empty next cycle.
REQ-037 Reset asserted while outst=2 and cnt=1 -> next cycle instr_valid=0; imem_addr restarts at RESET_PC.
REQ-038 Redirect to 32'hFFFF_FFFC -> instr_pc 32'hFFFF_FFFC then 32'h0000_0000 (wrap).

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
// The optional same-cycle response bypass is enabled by defining FETCH_BYPASS_EN.
package fetch_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] PC_STEP = 32'd4;
    localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Width of the outstanding/discard counters; in-flight requests are bounded by memory latency.
    localparam int OUTST_W = 8;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [WORD_W-1:0] align_pc(input logic [WORD_W-1:0] pc);
        return {pc[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: circular FIFO of fetch entries with push/pop/flush and occupancy count.
// The head entry reads as all zeros while the buffer is empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A push into a full buffer is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

    assign head = (count != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential fetches, buffers in-order responses, handles redirects.
// Defining FETCH_BYPASS_EN lets a response reach decode in its arrival cycle when the buffer is empty.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                DEPTH    = 2,
    parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic              instr_valid,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] instr_pc,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = OUTST_W + 1;

    logic [WORD_W-1:0]  fetch_pc;
    logic [WORD_W-1:0]  resp_pc;
    logic [OUTST_W-1:0] outst;
    logic [OUTST_W-1:0] disc;
    logic [CNT_W-1:0]   cnt;
    logic [OCC_W-1:0]   occupancy;
    fetch_entry_t       head;
    fetch_entry_t       push_data;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    logic               resp_keep;
    logic               bypass_hit;
    logic               bypass_take;

    // Live requests plus buffered entries never exceed DEPTH, so every kept response has a slot.
    assign occupancy  = OCC_W'(outst - disc) + OCC_W'(cnt);
    assign imem_req   = !reset && !redirect && (occupancy < OCC_W'(DEPTH));
    assign imem_addr  = fetch_pc;

    assign fifo_empty = (cnt == '0);
    assign resp_keep  = imem_rvalid && (disc == '0) && !redirect;

`ifdef FETCH_BYPASS_EN
    assign bypass_hit = fifo_empty && resp_keep;
`else
    assign bypass_hit = 1'b0;
`endif

    // Decode handshake: an instruction transfers in any cycle where instr_valid and instr_ready
    // are both high; instr/instr_pc stay stable while instr_valid is high and instr_ready is low.
    assign instr_valid = !reset && (!fifo_empty || bypass_hit);
    assign bypass_take = bypass_hit && instr_ready;

    always_comb begin
        instr    = '0;
        instr_pc = '0;
        if (!reset) begin
            if (!fifo_empty) begin
                instr    = head.instr;
                instr_pc = head.pc;
            end else if (bypass_hit) begin
                instr    = imem_rdata;
                instr_pc = resp_pc;
            end
        end
    end

    assign fifo_pop  = instr_valid && instr_ready && !fifo_empty;
    assign fifo_push = resp_keep && !bypass_take;
    assign push_data = '{pc: resp_pc, instr: imem_rdata};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_data),
        .pop       (fifo_pop),
        .flush     (redirect),
        .head      (head),
        .count     (cnt)
    );

    // On redirect every request still in flight after this cycle's response becomes stale.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            outst    <= '0;
            disc     <= '0;
        end else begin
            if (redirect) begin
                fetch_pc <= align_pc(redirect_pc);
                resp_pc  <= align_pc(redirect_pc);
                disc     <= outst - OUTST_W'(imem_rvalid);
            end else begin
                if (imem_req) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (resp_keep) begin
                    resp_pc <= resp_pc + PC_STEP;
                end
                if (imem_rvalid && (disc != '0)) begin
                    disc <= disc - OUTST_W'(1);
                end
            end
            outst <= outst + OUTST_W'(imem_req) - OUTST_W'(imem_rvalid);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order latency memory, queue-based reference model checked every cycle,
// and directed scenarios with literal expectations (build with FETCH_BYPASS_EN for the bypass variant).
module tb_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
    localparam int FIRST_VALID = 1;
`else
    localparam int FIRST_VALID = 2;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int lat = 1;

    // Memory side: accepted requests waiting for their response cycle.
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];

    // Reference model: buffered pcs, requests in flight with a stale flag, next fetch pc.
    logic [31:0] exp_q[$];
    logic [31:0] fly_pc[$];
    bit          fly_stale[$];
    logic [31:0] m_fpc = RESET_PC;

    fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Memory driver plus per-cycle compare against the model.
    always @(negedge clk) begin
        int          stale_n;
        bit          e_req;
        bit          e_valid;
        bit          byp;
        logic [31:0] e_pc;
        logic [31:0] p;
        bit          s;
        if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_of(mem_addr_q[0]);
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        #1;
        if (reset) begin
            check("rst_imem_req", imem_req, 0);
            check("rst_instr_valid", instr_valid, 0);
            check("rst_instr", instr, 0);
            check("rst_instr_pc", instr_pc, 0);
            exp_q.delete();
            fly_pc.delete();
            fly_stale.delete();
            mem_addr_q.delete();
            mem_due_q.delete();
            m_fpc = RESET_PC;
        end else begin
            stale_n = 0;
            foreach (fly_stale[i]) if (fly_stale[i]) stale_n++;
            e_req = !redirect && (exp_q.size() + fly_pc.size() - stale_n < DEPTH);
            byp = 1'b0;
`ifdef FETCH_BYPASS_EN
            byp = (exp_q.size() == 0) && imem_rvalid && (stale_n == 0) && !redirect
                  && (fly_pc.size() > 0);
`endif
            e_valid = (exp_q.size() > 0) || byp;
            e_pc = (exp_q.size() > 0) ? exp_q[0] : (byp ? fly_pc[0] : 32'h0);
            check("imem_req", imem_req, e_req);
            if (e_req) check("imem_addr", imem_addr, m_fpc);
            check("instr_valid", instr_valid, e_valid);
            check("instr_pc", instr_pc, e_pc);
            check("instr", instr, e_valid ? word_of(e_pc) : 32'h0);

            if (exp_q.size() > 0 && instr_ready) void'(exp_q.pop_front());
            if (imem_rvalid && fly_pc.size() > 0) begin
                p = fly_pc.pop_front();
                s = fly_stale.pop_front();
                if (!s && !redirect && !(byp && instr_ready)) exp_q.push_back(p);
            end
            if (redirect) begin
                exp_q.delete();
                foreach (fly_stale[i]) fly_stale[i] = 1'b1;
                m_fpc = {redirect_pc[31:2], 2'b00};
            end else if (e_req) begin
                fly_pc.push_back(m_fpc);
                fly_stale.push_back(1'b0);
                m_fpc = m_fpc + 32'd4;
            end
            if (imem_req) begin
                mem_addr_q.push_back(imem_addr);
                mem_due_q.push_back(cyc + lat);
            end
        end
        cyc++;
    end

    // One reset cycle, then returns at the start of the first cycle after release.
    task automatic reset_for(input int l);
        @(negedge clk);
        reset    = 1'b1;
        redirect = 1'b0;
        lat      = l;
        #2;
        check("reset_instr_valid", instr_valid, 0);
        check("reset_imem_req", imem_req, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = pc;
        @(negedge clk);
        redirect = 1'b0;
    endtask

    task automatic wait_valid(input string name, input logic [31:0] exp_pc);
        bit found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            #2;
            if (instr_valid) found = 1'b1;
            else @(negedge clk);
        end
        if (found) begin
            check(name, instr_pc, exp_pc);
        end else begin
            tests++;
            fails++;
            $display("FAIL %s: no instr_valid within 30 cycles, expected pc %h", name, exp_pc);
        end
    endtask

    initial begin
        int          nreq;
        logic [39:0] pat;

        // Held reset
        repeat (3) @(negedge clk);
        #2;
        check("hold_reset_valid", instr_valid, 0);
        check("hold_reset_instr_pc", instr_pc, 0);

        // Streaming from reset, 1-cycle memory
        reset_for(1);
        instr_ready = 1'b1;
        #2;
        check("k0_req", imem_req, 1);
        check("k0_addr", imem_addr, RESET_PC);
        for (int k = 1; k <= FIRST_VALID + 1; k++) begin
            @(negedge clk);
            #2;
            if (k == 1) check("k1_addr", imem_addr, 32'h4);
            if (k == FIRST_VALID) begin
                check("first_valid", instr_valid, 1);
                check("first_pc", instr_pc, 32'h0);
            end
            if (k == FIRST_VALID + 1) begin
                check("second_valid", instr_valid, 1);
                check("second_pc", instr_pc, 32'h4);
            end
        end

        // Decode stalled for 10 cycles
        reset_for(1);
        instr_ready = 1'b0;
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            #2;
            if (imem_req) nreq++;
            @(negedge clk);
        end
        check("stall_req_count", nreq, 2);
        #2;
        check("stall_req_low", imem_req, 0);
        check("stall_valid", instr_valid, 1);
        check("stall_pc_held", instr_pc, 32'h0);
        @(negedge clk);
        instr_ready = 1'b1;
        #2;
        check("drain_pc0", instr_pc, 32'h0);
        @(negedge clk);
        #2;
        check("drain_pc4", instr_pc, 32'h4);

        // Redirect, response and pop in one cycle
        reset_for(1);
        instr_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h500;
        #2;
        check("rp_valid", instr_valid, 1);
        check("rp_pc", instr_pc, 32'h0);
        @(negedge clk);
        redirect = 1'b0;
        #2;
        check("rp_empty_after", instr_valid, 0);
        check("rp_req", imem_req, 1);
        check("rp_addr", imem_addr, 32'h500);

        // 3-cycle memory, redirect with two requests outstanding
        reset_for(3);
        instr_ready = 1'b1;
        #2;
        check("l3_addr0", imem_addr, RESET_PC);
        @(negedge clk);
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        #2;
        check("l3_req_suppressed", imem_req, 0);
        @(negedge clk);
        redirect = 1'b0;
        wait_valid("l3_first_pc", 32'h100);
        @(negedge clk);
        wait_valid("l3_second_pc", 32'h104);

        // Reset in the middle of traffic
        reset_for(1);
        #2;
        check("mid_rst_req", imem_req, 1);
        check("mid_rst_addr", imem_addr, RESET_PC);
        repeat (4) @(negedge clk);

        // Address wrap and low-bit masking
        do_redirect(32'hFFFF_FFFC);
        wait_valid("wrap_top_pc", 32'hFFFF_FFFC);
        @(negedge clk);
        #2;
        check("wrap_next_valid", instr_valid, 1);
        check("wrap_next_pc", instr_pc, 32'h0);
        do_redirect(32'h0000_0203);
        wait_valid("align_pc", 32'h200);

        // Back-to-back redirects
        reset_for(3);
        instr_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        @(negedge clk);
        redirect_pc = 32'h400;
        @(negedge clk);
        redirect = 1'b0;
        wait_valid("b2b_first_pc", 32'h400);
        @(negedge clk);
        wait_valid("b2b_second_pc", 32'h404);

        // Irregular decode backpressure with a redirect mid-stream, 2-cycle memory
        reset_for(2);
        pat = 40'hB5_3C_E1_9A_6F;
        for (int i = 0; i < 40; i++) begin
            instr_ready = pat[i];
            redirect    = (i == 20);
            redirect_pc = 32'h800;
            @(negedge clk);
        end
        redirect = 1'b0;
        instr_ready = 1'b1;
        repeat (8) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
